// File: rtl/volcado_registros.sv
// Register-file dump engine: walks read port 1 over indices 0..NREG-1 and
// streams each register out on a valid/ready beat, one register per fetch/send pair.
module volcado_registros #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic          CLK,
    input  logic          RSTa,
    input  logic          start,
    input  logic          abort,
    output logic [AW-1:0] rdAddr,
    input  logic [DW-1:0] rdData,
    output logic          dump_valid,
    input  logic          dump_ready,
    output logic [DW-1:0] dump_data,
    output logic [AW-1:0] dump_idx,
    output logic          dump_last,
    output logic          busy,
    output logic          done
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   rd_addr_q, rd_addr_d;
    logic [DW-1:0]   data_q, data_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            last_q, last_d;
    logic            valid_q, valid_d;
    logic            done_q, done_d;

    // State and output registers; reset clears everything immediately, even mid-dump.
    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            state_q   <= IDLE;
            rd_addr_q <= {AW{1'b0}};
            data_q    <= {DW{1'b0}};
            idx_q     <= {AW{1'b0}};
            last_q    <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            data_q    <= data_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic; abort outranks both start and a coincident handshake.
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        data_d    = data_q;
        idx_d     = idx_q;
        last_d    = last_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (start) begin
                    rd_addr_d = {AW{1'b0}};
                    state_d   = FETCH;
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                if (abort) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    data_d  = rdData;
                    idx_d   = rd_addr_q;
                    last_d  = (rd_addr_q == LAST_IDX);
                    valid_d = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (abort) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    state_d = IDLE;
                end else if (valid_q && dump_ready) begin
                    valid_d = 1'b0;
                    if (last_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        rd_addr_d = rd_addr_q + AW'(1);
                        state_d   = FETCH;
                    end
                end else begin
                    state_d = SEND;
                end
            end
            default: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign rdAddr     = rd_addr_q;
    assign dump_valid = valid_q;
    assign dump_data  = data_q;
    assign dump_idx   = idx_q;
    assign dump_last  = last_q;
    assign done       = done_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_volcado_registros.sv
// Scoreboard bench for volcado_registros: expected beats are queued before each
// dump and a negedge monitor checks every presented beat against the queue head.
module tb_volcado_registros;

    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic          CLK = 1'b0;
    logic          RSTa;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          dump_ready = 1'b1;
    logic [AW-1:0] rdAddr;
    logic [DW-1:0] rdData;
    logic          dump_valid;
    logic [DW-1:0] dump_data;
    logic [AW-1:0] dump_idx;
    logic          dump_last;
    logic          busy;
    logic          done;

    logic [DW-1:0] regs     [NREG];
    logic [DW-1:0] exp_regs [NREG];

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t sb[$];
    int nvec = 0;
    int nerr = 0;

    volcado_registros #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
        .CLK        (CLK),
        .RSTa       (RSTa),
        .start      (start),
        .abort      (abort),
        .rdAddr     (rdAddr),
        .rdData     (rdData),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_data  (dump_data),
        .dump_idx   (dump_idx),
        .dump_last  (dump_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 CLK = ~CLK;

    // Register file model with a combinational read port.
    assign rdData = regs[rdAddr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic push_dump();
        beat_t b;
        for (int i = 0; i < NREG; i++) begin
            b.idx  = AW'(i);
            b.data = exp_regs[i];
            b.last = (i == NREG - 1);
            sb.push_back(b);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {18'd0, rdAddr, dump_data, dump_idx, dump_valid, dump_last, busy, done}, 64'd0);
    endtask

    // Drives one dump for a fixed cycle budget, injecting stalls, abort, a second start or writes.
    task automatic run_dump(input int stall_idx, input int stall_len, input bit do_abort,
                            input int again_idx, input bit do_write,
                            output int dones, output int done_at, output int busy_low);
        bit stalled  = 1'b0;
        bit aborting = 1'b0;
        bit again    = 1'b0;
        bit wrote    = 1'b0;
        int hold     = 0;
        dones = 0;
        done_at = -1;
        busy_low = 0;
        for (int n = 1; n <= 80; n++) begin
            step();
            start = 1'b0;
            if (done) begin
                dones++;
                if (done_at < 0) done_at = n;
            end
            if (done_at < 0 && !do_abort && !busy) busy_low++;
            if (aborting) begin
                abort = 1'b0;
                aborting = 1'b0;
                check("abort_clears_valid_busy", {62'd0, dump_valid, busy}, 64'd0);
                dump_ready = 1'b1;
            end else if (stalled && hold < stall_len) begin
                hold++;
                if (hold == stall_len) begin
                    if (do_abort) begin
                        abort = 1'b1;
                        aborting = 1'b1;
                    end else begin
                        dump_ready = 1'b1;
                    end
                end
            end else if (!stalled && stall_idx >= 0 && dump_valid && int'(dump_idx) == stall_idx) begin
                dump_ready = 1'b0;
                stalled = 1'b1;
            end
            if (again_idx >= 0 && !again && dump_valid && int'(dump_idx) == again_idx) begin
                start = 1'b1;
                again = 1'b1;
            end
            if (do_write && !wrote && busy && !dump_valid && dump_idx == 5'd10) begin
                regs[24] = 32'h0000_BEEF;
                regs[5]  = 32'h0000_DEAD;
                wrote = 1'b1;
            end
        end
    endtask

    // Monitor: every presented beat must match the queue head; accepted beats pop it.
    initial begin
        beat_t e;
        forever begin
            @(negedge CLK);
            if (dump_valid) begin
                if (sb.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL unexpected_beat: got idx %0d data %0h, expected no beat", dump_idx, dump_data);
                end else begin
                    if (dump_ready) e = sb.pop_front();
                    else e = sb[0];
                    check(dump_ready ? "beat" : "stall_hold",
                          {26'd0, dump_idx, dump_data, dump_last},
                          {26'd0, e.idx, e.data, e.last});
                end
            end
        end
    end

    initial begin
        int dones, done_at, busy_low, k;
        for (int i = 0; i < NREG; i++) regs[i] = 32'd0;
        regs[13] = 32'h0000_A234;
        regs[16] = 32'h0000_1234;
        regs[24] = 32'h0000_2345;

        RSTa = 1'b1;
        #2 RSTa = 1'b0;
        #1 check_reset_outputs("reset_state");
        step();
        step();
        RSTa = 1'b1;
        check_reset_outputs("post_reset_idle");

        // Plain full dump with the consumer always ready.
        exp_regs = regs;
        push_dump();
        pulse_start();
        run_dump(-1, 0, 1'b0, -1, 1'b0, dones, done_at, busy_low);
        check("full_done_count", 64'(dones), 64'd1);
        check("full_done_edge", 64'(done_at), 64'd64);
        check("full_busy_low", 64'(busy_low), 64'd0);
        check("full_sb_empty", 64'(sb.size()), 64'd0);

        // Backpressure: five stalled cycles on beat 13.
        push_dump();
        pulse_start();
        run_dump(13, 5, 1'b0, -1, 1'b0, dones, done_at, busy_low);
        check("stall_done_count", 64'(dones), 64'd1);
        check("stall_done_edge", 64'(done_at), 64'd69);
        check("stall_sb_empty", 64'(sb.size()), 64'd0);

        // Abort while beat 20 is stalled, then restart from index 0.
        push_dump();
        pulse_start();
        run_dump(20, 1, 1'b1, -1, 1'b0, dones, done_at, busy_low);
        check("abort_no_done", 64'(dones), 64'd0);
        check("abort_left_beats", 64'(sb.size()), 64'd12);
        sb.delete();
        push_dump();
        pulse_start();
        run_dump(-1, 0, 1'b0, -1, 1'b0, dones, done_at, busy_low);
        check("restart_done_count", 64'(dones), 64'd1);
        check("restart_sb_empty", 64'(sb.size()), 64'd0);

        // Start pulsed mid-dump is neither honoured nor queued.
        push_dump();
        pulse_start();
        run_dump(-1, 0, 1'b0, 5, 1'b0, dones, done_at, busy_low);
        check("restart_ignored_dones", 64'(dones), 64'd1);
        check("restart_ignored_edge", 64'(done_at), 64'd64);
        check("restart_ignored_idle", {63'd0, busy}, 64'd0);

        // Writes after beat 10: x24 visible now, x5 only in the next dump.
        exp_regs = regs;
        exp_regs[24] = 32'h0000_BEEF;
        push_dump();
        pulse_start();
        run_dump(-1, 0, 1'b0, -1, 1'b1, dones, done_at, busy_low);
        check("write_done_count", 64'(dones), 64'd1);
        check("write_sb_empty", 64'(sb.size()), 64'd0);
        exp_regs[5] = 32'h0000_DEAD;
        push_dump();
        pulse_start();
        run_dump(-1, 0, 1'b0, -1, 1'b0, dones, done_at, busy_low);
        check("write_next_done", 64'(dones), 64'd1);
        check("write_next_sb_empty", 64'(sb.size()), 64'd0);

        // Asynchronous reset between edges while beat 7 is on the bus.
        push_dump();
        pulse_start();
        k = 0;
        while (k < 40 && !(dump_valid && dump_idx == 5'd7)) begin
            step();
            k++;
        end
        check("reach_idx7", {57'd0, dump_valid, dump_idx}, {57'd0, 1'b1, 5'd7});
        #2 RSTa = 1'b0;
        #1 check_reset_outputs("async_reset_mid_dump");
        sb.delete();
        step();
        step();
        check_reset_outputs("reset_held");
        RSTa = 1'b1;
        push_dump();
        pulse_start();
        run_dump(-1, 0, 1'b0, -1, 1'b0, dones, done_at, busy_low);
        check("after_reset_done_edge", 64'(done_at), 64'd64);
        check("after_reset_sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
